// File: rtl/tv_truth_table_sweeper_if.sv
// Stimulus/capture bundle between the truth-table sweeper and whoever drives it.
// The sweeper (slave) drives a/b/c into the function block and reports results.
interface tv_truth_table_sweeper_if;
  logic       start;
  logic [7:0] exp_table;
  logic       f_in;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] truth_table;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_fail;

  modport master (
    output start, exp_table, f_in,
    input  a, b, c, busy, done, pass, truth_table, mismatch_cnt, first_fail
  );

  modport slave (
    input  start, exp_table, f_in,
    output a, b, c, busy, done, pass, truth_table, mismatch_cnt, first_fail
  );
endinterface

// File: rtl/tv_truth_table_sweeper.sv
// Sweeps {a,b,c} through 000..111, holds each vector SETTLE_CYCLES+1 cycles,
// captures the function output into an 8-bit table and compares it to a latched expectation.
module tv_truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  tv_truth_table_sweeper_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FINISH} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [7:0] r_exp;
  logic [7:0] r_table;
  logic [3:0] r_mis;
  logic [2:0] r_first;
  logic       r_pass;
  logic       r_busy;
  logic       r_done;
  logic       w_miss;
  logic [3:0] w_mis_next;

  assign w_miss     = (bus.f_in != r_exp[r_idx]);
  assign w_mis_next = r_mis + {3'b000, w_miss};

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = HOLD;
      HOLD:    if (r_cnt == 4'd0) w_next = SAMPLE;
      SAMPLE:  w_next = (r_idx == 3'd7) ? FINISH : HOLD;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_table <= '0;
      r_mis   <= '0;
      r_first <= '0;
      r_pass  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // busy/done are decoded from the next state so they line up with the state itself
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == FINISH);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_exp   <= bus.exp_table;
            r_idx   <= '0;
            r_table <= '0;
            r_mis   <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
            r_cnt   <= SETTLE_LOAD;
          end
        end
        HOLD: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        SAMPLE: begin
          r_table[r_idx] <= bus.f_in;
          r_mis          <= w_mis_next;
          if (w_miss && (r_mis == 4'd0)) r_first <= r_idx;
          if (r_idx == 3'd7) begin
            // verdict includes vector 7 so pass is already valid alongside done
            r_pass <= (w_mis_next == 4'd0);
          end else begin
            r_idx <= r_idx + 3'd1;
            r_cnt <= SETTLE_LOAD;
          end
        end
        FINISH: r_idx <= '0;
        default: r_idx <= '0;
      endcase
    end
  end

  assign bus.a            = r_idx[2];
  assign bus.b            = r_idx[1];
  assign bus.c            = r_idx[0];
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.pass         = r_pass;
  assign bus.truth_table  = r_table;
  assign bus.mismatch_cnt = r_mis;
  assign bus.first_fail   = r_first;

endmodule
